// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, header field
// positions and the default output buffer depth.
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int HDR_FLAG_BIT = DATA_W;
    localparam int LEN_MSB      = 7;
    localparam int LEN_LSB      = 2;
    localparam int ADDR_MSB     = 1;
    localparam int ADDR_LSB     = 0;
    localparam int FIFO_DEPTH   = 16;
    localparam int CNT_W        = LEN_MSB - LEN_LSB + 1;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array of one router output buffer:
// synchronous write, combinational read, cleared on reset.
module router_fifo_mem #(
    parameter int DEPTH = router_pkg::FIFO_DEPTH,
    parameter int WIDTH = router_pkg::DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_out_fifo.sv
// Per-port output buffer of the 1x3 router: ordered byte delivery,
// packet length tracking from the header and a soft flush.
module router_out_fifo #(
    parameter int DEPTH  = router_pkg::FIFO_DEPTH,
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W:0]   rd_entry;
    logic              do_wr;
    logic              do_rd;

    // Flags come from pre-edge pointers, so a write while full is
    // dropped even when a read happens in the same cycle.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign do_wr = write_enb && !full && !soft_reset;
    assign do_rd = read_enb && !empty && !soft_reset;

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (do_wr),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  ({lfd_state, data_in}),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (rd_entry)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_entry[DATA_W-1:0];
                // Header length covers payload; the extra one is parity.
                if (rd_entry[DATA_W]) begin
                    count <= rd_entry[LEN_MSB:LEN_LSB] + CNT_ONE;
                end else if (count != '0) begin
                    count <= count - CNT_ONE;
                end
            end else if (count == '0) begin
                data_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_router_out_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int errors = 0;
    int checks = 0;

    logic [8:0] mq[$];
    int         m_cnt;
    logic [7:0] m_dout;

    typedef struct {
        bit         wr;
        bit         rd;
        bit         lfd;
        logic [7:0] din;
        logic [7:0] dout;
        bit         emp;
        bit         ful;
    } vec_t;

    vec_t tbl[13];

    router_out_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
    endfunction

    function automatic void model_step(input bit wr, input bit rd,
                                       input bit sr, input bit lfd,
                                       input logic [7:0] din);
        bit was_full;
        bit was_empty;
        logic [8:0] e;
        if (sr) begin
            model_clear();
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (rd && !was_empty) begin
            e = mq.pop_front();
            m_dout = e[7:0];
            if (e[8])
                m_cnt = (int'(e[7:2]) + 1) % 64;
            else if (m_cnt != 0)
                m_cnt = m_cnt - 1;
        end else if (m_cnt == 0) begin
            m_dout = 8'h00;
        end
        if (wr && !was_full)
            mq.push_back({lfd, din});
    endfunction

    task automatic cycle(input bit wr, input bit rd, input bit sr,
                         input bit lfd, input logic [7:0] din);
        @(negedge clk);
        write_enb  = wr;
        read_enb   = rd;
        soft_reset = sr;
        lfd_state  = lfd;
        data_in    = din;
        @(posedge clk);
        model_step(wr, rd, sr, lfd, din);
        #1;
        chk("model_dout", 32'(data_out), 32'(m_dout));
        chk("model_empty", 32'(empty), 32'(mq.size() == 0));
        chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
    endtask

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        model_clear();

        tbl[0]  = '{1, 0, 1, 8'h0D, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'h11, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 0, 8'h22, 8'h00, 0, 0};
        tbl[3]  = '{1, 0, 0, 8'h33, 8'h00, 0, 0};
        tbl[4]  = '{1, 0, 0, 8'h0D, 8'h00, 0, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 8'h0D, 0, 0};
        tbl[6]  = '{0, 1, 0, 8'h00, 8'h11, 0, 0};
        tbl[7]  = '{0, 0, 0, 8'h00, 8'h11, 0, 0};
        tbl[8]  = '{0, 1, 0, 8'h00, 8'h22, 0, 0};
        tbl[9]  = '{0, 1, 0, 8'h00, 8'h33, 0, 0};
        tbl[10] = '{0, 1, 0, 8'h00, 8'h0D, 1, 0};
        tbl[11] = '{0, 0, 0, 8'h00, 8'h00, 1, 0};
        tbl[12] = '{0, 1, 0, 8'h00, 8'h00, 1, 0};

        #2;
        chk("rst_dout", 32'(data_out), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single packet, including a hold cycle mid-packet
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].lfd, tbl[i].din);
            chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].ful));
        end

        // Fill to DEPTH, then a dropped write
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
            chk("fill_full", 32'(full), 32'(i == DEPTH - 1));
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        chk("drop_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("full_rw_dout", 32'(data_out), 32'h40);
        chk("full_rw_full", 32'(full), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain_dout", 32'(data_out), 32'(8'(8'h40 + i)));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Prefill then concurrent access across the address wrap
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h8A + k));
            chk("wrap_dout", 32'(data_out), 32'(8'(8'h80 + k)));
            chk("wrap_empty", 32'(empty), 32'd0);
            chk("wrap_full", 32'(full), 32'd0);
        end

        // Soft reset beats simultaneous read and write
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_dout", 32'(data_out), 32'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("sr_nowrite_empty", 32'(empty), 32'd1);
        chk("sr_nowrite_dout", 32'(data_out), 32'h00);

        // Asynchronous reset mid-packet, then a zero-length header
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h0D);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_dout", 32'(data_out), 32'h00);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_full", 32'(full), 32'd0);
        model_clear();
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("len0_hdr", 32'(data_out), 32'h01);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("len0_par", 32'(data_out), 32'h55);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("len0_idle", 32'(data_out), 32'h00);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(bit'($urandom_range(0, 99) < 55),
                  bit'($urandom_range(0, 99) < 50),
                  bit'($urandom_range(0, 99) < 2),
                  bit'($urandom_range(0, 99) < 20),
                  8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
